right_shift_sequencer: RTL and testbench

- Sequential right-shift datapath component; the counterpart of the combinational x1 left shifter.
- Holds a WIDTH-bit register and supports three operations:
  - parallel load;
  - single-step right shift on command;
  - multi-cycle shift-by-N sequence with busy/done handshake.
- Fill bit (cin) enters at the MSB. Each bit shifted out of the LSB appears on cout.
- Sits beside the shifter/ALU blocks as the serial-out / divide-by-2^N path.

---
 rtl/right_shift_pkg.sv | 16 +
 rtl/right_shifter_x1.sv | 22 ++
 rtl/right_shift_sequencer.sv | 129 ++++++++++++
 tb/tb_right_shift_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/right_shift_pkg.sv
// Shared constants and state encoding for the right-shift sequencer.
package right_shift_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT,
    StDone  = ST_DONE
  } state_e;

endpackage

// File: rtl/right_shifter_x1.sv
// Combinational one-bit right step: fill bit enters at the MSB, the LSB falls out on cout.
module right_shifter_x1 #(
  parameter int unsigned WIDTH = right_shift_pkg::DEF_WIDTH
) (
  output logic [WIDTH-1:0] out,
  output logic             cout,
  input  logic [WIDTH-1:0] in,
  input  logic             cin,
  input  logic             sh
);

  // Pass-through when not shifting; cout is only meaningful when sh is high.
  always_comb begin
    out  = in;
    cout = 1'b0;
    if (sh) begin
      out  = {cin, in[WIDTH-1:1]};
      cout = in[0];
    end
  end

endmodule

// File: rtl/right_shift_sequencer.sv
// Right-shift register with parallel load, single-step shift and a shift-by-N sequence.
module right_shift_sequencer
  import right_shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned AW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             sh,
  input  logic             start,
  input  logic [AW-1:0]    amt,
  input  logic             cin,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam logic [AW-1:0] MaxAmt = AW'(WIDTH);

  state_e           state_q, state_d;
  logic [AW-1:0]    count_q, count_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             step_en;
  logic             step_fill;
  logic [WIDTH-1:0] step_out;
  logic             step_cout;

  right_shifter_x1 #(
    .WIDTH(WIDTH)
  ) u_shifter (
    .out (step_out),
    .cout(step_cout),
    .in  (out_q),
    .cin (step_fill),
    .sh  (step_en)
  );

  // Next-state, datapath select and handshake outputs.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    fill_d    = fill_q;
    out_d     = out_q;
    cout_d    = cout_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    step_en   = 1'b0;
    step_fill = cin;

    unique case (state_q)
      StIdle: begin
        if (load) begin
          out_d  = in;
          cout_d = 1'b0;
        end else if (start) begin
          // Saturate so oversized counts become a full flush.
          count_d = (amt > MaxAmt) ? MaxAmt : amt;
          fill_d  = cin;
          if (count_d != '0) begin
            busy_d  = 1'b1;
            state_d = StShift;
          end else begin
            done_d  = 1'b1;
            state_d = StDone;
          end
        end else if (sh) begin
          step_en = 1'b1;
          out_d   = step_out;
          cout_d  = step_cout;
        end
      end
      StShift: begin
        step_en   = 1'b1;
        step_fill = fill_q;
        out_d     = step_out;
        cout_d    = step_cout;
        count_d   = count_q - 1'b1;
        if (count_q == AW'(1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any sequence without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      fill_q  <= 1'b0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_right_shift_sequencer.sv
// Directed bench for right_shift_sequencer with hand-computed expectations.
module tb_right_shift_sequencer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned AW    = 3;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in;
  logic             load;
  logic             sh;
  logic             start;
  logic [AW-1:0]    amt;
  logic             cin;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             busy;
  logic             done;

  int total;
  int bad;

  right_shift_sequencer #(
    .WIDTH(WIDTH),
    .AW   (AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (in),
    .load (load),
    .sh   (sh),
    .start(start),
    .amt  (amt),
    .cin  (cin),
    .out  (out),
    .cout (cout),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load  = 1'b0;
    sh    = 1'b0;
    start = 1'b0;
    amt   = '0;
    cin   = 1'b0;
    in    = '0;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    load = 1'b1;
    in   = v;
    step();
    load = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();

    // Reset with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in    = 4'($urandom);
      load  = 1'($urandom);
      sh    = 1'($urandom);
      start = 1'($urandom);
      amt   = 3'($urandom);
      cin   = 1'($urandom);
      step();
    end
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_cout", 32'(cout), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    idle_inputs();
    rst_n = 1'b1;
    step();

    // Load and single steps.
    do_load(4'b0110);
    chk("ld_out", 32'(out), 32'h6);
    chk("ld_cout", 32'(cout), 32'h0);
    sh = 1'b1; cin = 1'b0;
    step();
    chk("sh0_out", 32'(out), 32'h3);
    chk("sh0_cout", 32'(cout), 32'h0);
    cin = 1'b1;
    step();
    chk("sh1_out", 32'(out), 32'h9);
    chk("sh1_cout", 32'(cout), 32'h1);
    sh = 1'b0; cin = 1'b0;
    step();
    chk("hold_out", 32'(out), 32'h9);
    chk("hold_cout", 32'(cout), 32'h1);

    // Sequence amt=2 with latched fill of 1.
    do_load(4'b1011);
    start = 1'b1; amt = 3'd2; cin = 1'b1;
    step();
    start = 1'b0; cin = 1'b0;
    chk("seq_e0_busy", 32'(busy), 32'h1);
    chk("seq_e0_out", 32'(out), 32'hB);
    step();
    chk("seq_e1_out", 32'(out), 32'hD);
    chk("seq_e1_cout", 32'(cout), 32'h1);
    chk("seq_e1_busy", 32'(busy), 32'h1);
    chk("seq_e1_done", 32'(done), 32'h0);
    step();
    chk("seq_e2_out", 32'(out), 32'hE);
    chk("seq_e2_cout", 32'(cout), 32'h1);
    chk("seq_e2_busy", 32'(busy), 32'h0);
    chk("seq_e2_done", 32'(done), 32'h1);
    step();
    chk("seq_e3_done", 32'(done), 32'h0);
    chk("seq_e3_busy", 32'(busy), 32'h0);

    // Saturating count: amt=7 behaves as 4.
    do_load(4'b1011);
    start = 1'b1; amt = 3'd7; cin = 1'b0;
    step();
    start = 1'b0; amt = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sat_mid_busy", 32'(busy), 32'h1);
      chk("sat_mid_done", 32'(done), 32'h0);
    end
    step();
    chk("sat_out", 32'(out), 32'h0);
    chk("sat_cout", 32'(cout), 32'h1);
    chk("sat_done", 32'(done), 32'h1);
    chk("sat_busy", 32'(busy), 32'h0);
    step();
    chk("sat_done_clr", 32'(done), 32'h0);

    // Zero count: immediate done, no busy, no shift.
    start = 1'b1; amt = 3'd0; cin = 1'b1;
    step();
    start = 1'b0; cin = 1'b0;
    chk("zero_done", 32'(done), 32'h1);
    chk("zero_busy", 32'(busy), 32'h0);
    chk("zero_out", 32'(out), 32'h0);
    chk("zero_cout", 32'(cout), 32'h1);
    step();
    chk("zero_done_clr", 32'(done), 32'h0);

    // load/sh ignored while shifting.
    do_load(4'b1000);
    start = 1'b1; amt = 3'd3; cin = 1'b0;
    step();
    start = 1'b0;
    load = 1'b1; in = 4'b1111; sh = 1'b1; cin = 1'b1;
    step();
    chk("ign_s1_out", 32'(out), 32'h4);
    step();
    chk("ign_s2_out", 32'(out), 32'h2);
    load = 1'b0; sh = 1'b0; cin = 1'b0;
    step();
    chk("ign_out", 32'(out), 32'h1);
    chk("ign_cout", 32'(cout), 32'h0);
    chk("ign_done", 32'(done), 32'h1);
    step();
    chk("ign_after_out", 32'(out), 32'h1);

    // Priority: load beats start and sh.
    do_load(4'b0101);
    load = 1'b1; in = 4'b1100; start = 1'b1; amt = 3'd2; sh = 1'b1;
    step();
    idle_inputs();
    chk("pri_out", 32'(out), 32'hC);
    chk("pri_cout", 32'(cout), 32'h0);
    chk("pri_busy", 32'(busy), 32'h0);
    chk("pri_done", 32'(done), 32'h0);
    step();
    chk("pri_busy2", 32'(busy), 32'h0);
    chk("pri_done2", 32'(done), 32'h0);
    chk("pri_out2", 32'(out), 32'hC);

    // Asynchronous reset mid-sequence.
    do_load(4'b1111);
    start = 1'b1; amt = 3'd4; cin = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("mid_busy_pre", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", 32'(out), 32'h0);
    chk("mid_rst_cout", 32'(cout), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mid_no_done", 32'(done), 32'h0);
      chk("mid_no_busy", 32'(busy), 32'h0);
    end
    chk("mid_out_held", 32'(out), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
